iob_eth_dma_burst: RTL and testbench
====================================

# iob_eth_dma_burst

Parametrised AXI4 master DMA engine for the Ethernet core, moving frames between the core's local frame buffers and system memory in either direction through one shared AXI4 master port. It supersedes the fixed 32-bit split read/write DMA pair with a single engine that has:
- configurable data width and maximum burst length;
- automatic burst splitting at 4 KB boundaries;
- sticky error reporting from AXI responses.

It sits between the Ethernet register/control logic, the TX/RX frame buffer RAMs and the system AXI interconnect.

## Interface
- DATA_W, 32: AXI and buffer data width; 32, 64 or 128.
- AXI_ADDR_W, 32: AXI address width.
- AXI_ID_W, 1: AXI ID width.
- LEN_W, 11: width of transfer length in beats; also the buffer address width.
- MAX_BURST_LEN, 16: maximum beats per burst; power of 2, at most 256.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dma_addr  in  AXI_ADDR_W  start byte address, aligned to DATA_W/8.
- dma_len  in  LEN_W  transfer length in beats.
- dma_dir  in  1  1 = buffer to memory (AXI write); 0 = memory to buffer (AXI read).
- dma_run  in  1  start request; sampled only when dma_ready=1.
- dma_ready  out  1  engine idle.
- dma_error  out  1  sticky; a non-OKAY response or rlast mismatch occurred in the current/last transfer.
- buf_wdata  out  DATA_W  read-direction data to the RX buffer.
- buf_waddr  out  LEN_W  RX buffer write address.
- buf_we  out  1  RX buffer write enable.
- buf_raddr  out  LEN_W  TX buffer read address; the RAM returns data one cycle later.
- buf_rdata  in  DATA_W  TX buffer read data.
- m_axi_aw*  AXI4 write-address channel: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid out; awready in.
- m_axi_w*  AXI4 write-data channel: wdata, wstrb, wlast, wvalid out; wready in.
- m_axi_b*  AXI4 write-response channel: bid, bresp, bvalid in; bready out.
- m_axi_ar*  AXI4 read-address channel: same fields as aw, ar prefix.
- m_axi_r*  AXI4 read-data channel: rid, rdata, rresp, rlast, rvalid in; rready out.

## Operation
- **Constant AXI fields:**
  - id = 0;
  - size = log2(DATA_W/8);
  - burst = INCR (2'b01);
  - lock = 0; cache = 4'b0011; prot = 3'b010; qos = 0;
  - wstrb = all ones.
- **FSM states:** IDLE, CALC, ADDR, DATA, RESP.
  - IDLE → CALC on dma_run=1 with dma_len≠0. Latches addr/len/dir, clears dma_error, zeroes the buffer pointer.
  - CALC computes the beat count for this burst: min(remaining, MAX_BURST_LEN, (4096 − addr[11:0])/(DATA_W/8)). A burst never crosses a 4 KB boundary.
  - ADDR drives a*len = beats−1 and holds a*valid until a*ready.
  - DATA:
    - Read: rready=1 for the whole state. Each rvalid&rready writes rdata to buf_waddr and increments the pointer.
    - Write: beats are presented in order from buf_raddr.
  - RESP (write only): bready=1 until bvalid.
  - After a burst, addr += beats·DATA_W/8 and remaining −= beats. Go to CALC if remaining≠0, otherwise IDLE.
- **Error (dma_error set):**
  - rresp≠OKAY on any beat;
  - bresp≠OKAY;
  - rlast disagreeing with the local beat count.
  - The transfer continues to completion; an error never aborts it.
- **Idle/start rules:**
  - dma_run with dma_len=0 generates no AXI traffic; dma_ready stays 1 and dma_error is cleared.
  - dma_run while busy is ignored.
- **Write data path:** a one-entry holding register covers the buffer read latency.
  - wvalid is asserted only when the register is valid.
  - buf_raddr advances only when the register will be free next cycle.
  - No beat may be duplicated or skipped under any wready pattern.
  - wlast is asserted on the final beat of each burst.
- Only one burst is outstanding at a time. The AW of the next burst is not issued before the B of the current one.

## Timing
- **Reset (rst_n=0):** takes effect immediately and asynchronously, including mid-burst. On exit the engine is in IDLE with no pending state.
  - dma_ready=1, dma_error=0.
  - All valids/readies = 0.
  - Addresses, lengths, buf_waddr, buf_raddr = 0; buf_we = 0.
- dma_run sampled at cycle T → dma_ready=0 at T+1 → a*valid=1 at T+2 (CALC takes one cycle).
- a*valid and all a* fields are stable from assertion until handshake.
- W data stalls hold wdata/wlast stable while wvalid=1 and wready=0.
- buf_we is asserted in the same cycle as the rvalid&rready handshake, with registered address/data: a single-cycle pulse per beat, buffer written at the next edge.
- **Done timing:** dma_ready=1 in the cycle after the final handshake. The final handshake is the last B (write) or the last R beat (read).
- **Inter-burst gap:** a new a*valid appears 2 cycles after the previous burst completes.
- **Arithmetic:** address arithmetic is modulo 2^AXI_ADDR_W; lengths are unsigned.

## Test plan
- **Read split:** DATA_W=32, read, addr 0x1000, len 40.
  - ARs at 0x1000/0x1040/0x1080 with arlen 15/15/7.
  - buf_we writes addresses 0..39 with the matching rdata.
  - dma_ready returns 1; dma_error=0.
- **4 KB split on write:** write, addr 0x0FF8, len 4.
  - AW 0x0FF8 awlen 1, then AW 0x1000 awlen 1.
  - wdata = buffer words 0..3; wlast on beats 2 and 4.
- **Backpressure:** write, len 20, with awready delayed 5 cycles and wready toggling every cycle.
  - Exactly 20 W beats, in order, with no duplicates.
  - Then read, len 20, with rvalid gaps → buffer contents match.
- **Error reporting:** bresp=SLVERR on burst 2 of a 3-burst write.
  - All 3 bursts complete; dma_error=1 after dma_ready=1.
  - Next dma_run clears dma_error.
- **Reset mid-operation:** rst_n=0 during beat 5 of a read burst.
  - Immediately: rready=0, arvalid=0, dma_ready=1.
  - After release, a new len-8 read completes normally.
- **Ignored/zero starts:**
  - dma_run pulsed while busy → no extra AR.
  - dma_run with len=0 → no AXI activity; dma_ready stays 1.

Source files
------------

// File: rtl/iob_eth_dma_burst.sv
// AXI4 master DMA engine moving Ethernet frames between the local frame buffers
// and system memory, splitting transfers into bursts that never cross 4 KB.
module iob_eth_dma_burst #(
  parameter int DATA_W        = 32,
  parameter int AXI_ADDR_W    = 32,
  parameter int AXI_ID_W      = 1,
  parameter int LEN_W         = 11,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AXI_ADDR_W-1:0] dma_addr,
  input  logic [LEN_W-1:0]      dma_len,
  input  logic                  dma_dir,
  input  logic                  dma_run,
  output logic                  dma_ready,
  output logic                  dma_error,
  output logic [DATA_W-1:0]     buf_wdata,
  output logic [LEN_W-1:0]      buf_waddr,
  output logic                  buf_we,
  output logic [LEN_W-1:0]      buf_raddr,
  input  logic [DATA_W-1:0]     buf_rdata,
  output logic [AXI_ID_W-1:0]   m_axi_awid,
  output logic [AXI_ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [AXI_ID_W-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [AXI_ID_W-1:0]   m_axi_arid,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [AXI_ID_W-1:0]   m_axi_rid,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SIZE   = $clog2(STRB_W);
  localparam logic [2:0] AXI_SIZE = 3'(SIZE);
  localparam logic [LEN_W-1:0] PTR_ONE = LEN_W'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]            state_r;
  logic [AXI_ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]      rem_r;
  logic                  dir_r;
  logic                  error_r;
  logic [8:0]            beats_r;
  logic [8:0]            beat_cnt_r;
  logic [8:0]            issued_r;
  logic [LEN_W-1:0]      ptr_r;
  logic [AXI_ADDR_W-1:0] ax_addr_r;
  logic [7:0]            ax_len_r;
  logic                  awvalid_r;
  logic                  arvalid_r;
  logic                  rready_r;
  logic                  bready_r;
  logic [DATA_W-1:0]     hold_r;
  logic                  hold_v_r;
  logic                  rd_pend_r;

  logic [12:0]           page_beats_s;
  logic [8:0]            beats_a_s;
  logic [8:0]            beats_s;
  logic                  r_hs_s;
  logic                  w_hs_s;
  logic                  b_hs_s;
  logic                  last_beat_s;
  logic                  burst_done_s;
  logic                  rd_issue_s;
  logic [AXI_ADDR_W-1:0] addr_next_s;
  logic [LEN_W-1:0]      rem_next_s;
  logic                  unused_s;

  // Burst size is the smallest of remaining beats, the burst cap and the beats left in the 4 KB page.
  assign page_beats_s = (13'd4096 - {1'b0, addr_r[11:0]}) >> SIZE;
  assign beats_a_s    = (32'(rem_r) < 32'(MAX_BURST_LEN)) ? 9'(rem_r) : 9'(MAX_BURST_LEN);
  assign beats_s      = ({4'b0000, beats_a_s} > page_beats_s) ? 9'(page_beats_s) : beats_a_s;

  assign r_hs_s       = m_axi_rvalid & rready_r;
  assign w_hs_s       = hold_v_r & m_axi_wready;
  assign b_hs_s       = m_axi_bvalid & bready_r;
  assign last_beat_s  = (beat_cnt_r == (beats_r - 9'd1));
  assign burst_done_s = (r_hs_s & last_beat_s) | b_hs_s;
  assign addr_next_s  = addr_r + (AXI_ADDR_W'(beats_r) << SIZE);
  assign rem_next_s   = rem_r - LEN_W'(beats_r);
  // A buffer read is launched only if the holding register is guaranteed free when its data lands.
  assign rd_issue_s   = (state_r == S_DATA) & dir_r & (issued_r != beats_r) & ~rd_pend_r
                        & (~hold_v_r | w_hs_s);
  assign unused_s     = ^{m_axi_bid, m_axi_rid};

  // Transfer sequencing, burst bookkeeping and the write-data holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      addr_r     <= {AXI_ADDR_W{1'b0}};
      rem_r      <= {LEN_W{1'b0}};
      dir_r      <= 1'b0;
      error_r    <= 1'b0;
      beats_r    <= 9'd0;
      beat_cnt_r <= 9'd0;
      issued_r   <= 9'd0;
      ptr_r      <= {LEN_W{1'b0}};
      ax_addr_r  <= {AXI_ADDR_W{1'b0}};
      ax_len_r   <= 8'd0;
      awvalid_r  <= 1'b0;
      arvalid_r  <= 1'b0;
      rready_r   <= 1'b0;
      bready_r   <= 1'b0;
      hold_r     <= {DATA_W{1'b0}};
      hold_v_r   <= 1'b0;
      rd_pend_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (dma_run) begin
            error_r <= 1'b0;
            if (dma_len != {LEN_W{1'b0}}) begin
              addr_r  <= dma_addr;
              rem_r   <= dma_len;
              dir_r   <= dma_dir;
              ptr_r   <= {LEN_W{1'b0}};
              state_r <= S_CALC;
            end
          end
        end
        S_CALC: begin
          beats_r    <= beats_s;
          beat_cnt_r <= 9'd0;
          issued_r   <= 9'd0;
          ax_addr_r  <= addr_r;
          ax_len_r   <= 8'(beats_s - 9'd1);
          awvalid_r  <= dir_r;
          arvalid_r  <= ~dir_r;
          state_r    <= S_ADDR;
        end
        S_ADDR: begin
          if ((awvalid_r & m_axi_awready) | (arvalid_r & m_axi_arready)) begin
            awvalid_r <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= ~dir_r;
            state_r   <= S_DATA;
          end
        end
        S_DATA: begin
          if (dir_r) begin
            if (w_hs_s) begin
              beat_cnt_r <= beat_cnt_r + 9'd1;
              if (last_beat_s) begin
                bready_r <= 1'b1;
                state_r  <= S_RESP;
              end
            end
          end else if (r_hs_s) begin
            beat_cnt_r <= beat_cnt_r + 9'd1;
            ptr_r      <= ptr_r + PTR_ONE;
            if ((m_axi_rresp != 2'b00) || (m_axi_rlast != last_beat_s)) begin
              error_r <= 1'b1;
            end
            if (last_beat_s) begin
              rready_r <= 1'b0;
            end
          end
        end
        S_RESP: begin
          if (b_hs_s) begin
            bready_r <= 1'b0;
            if (m_axi_bresp != 2'b00) begin
              error_r <= 1'b1;
            end
          end
        end
        default: state_r <= S_IDLE;
      endcase

      if (burst_done_s) begin
        addr_r  <= addr_next_s;
        rem_r   <= rem_next_s;
        state_r <= (rem_next_s == {LEN_W{1'b0}}) ? S_IDLE : S_CALC;
      end

      if (rd_issue_s) begin
        ptr_r    <= ptr_r + PTR_ONE;
        issued_r <= issued_r + 9'd1;
      end
      rd_pend_r <= rd_issue_s;
      if (rd_pend_r) begin
        hold_r   <= buf_rdata;
        hold_v_r <= 1'b1;
      end else if (w_hs_s) begin
        hold_v_r <= 1'b0;
      end
    end
  end

  assign dma_ready     = (state_r == S_IDLE);
  assign dma_error     = error_r;
  assign buf_wdata     = m_axi_rdata;
  assign buf_waddr     = ptr_r;
  assign buf_we        = r_hs_s;
  assign buf_raddr     = ptr_r;

  assign m_axi_awid    = {AXI_ID_W{1'b0}};
  assign m_axi_awaddr  = ax_addr_r;
  assign m_axi_awlen   = ax_len_r;
  assign m_axi_awsize  = AXI_SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b010;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_wdata   = hold_r;
  assign m_axi_wstrb   = {STRB_W{1'b1}};
  assign m_axi_wlast   = hold_v_r & last_beat_s;
  assign m_axi_wvalid  = hold_v_r;
  assign m_axi_bready  = bready_r;
  assign m_axi_arid    = {AXI_ID_W{1'b0}};
  assign m_axi_araddr  = ax_addr_r;
  assign m_axi_arlen   = ax_len_r;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b010;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_rready  = rready_r;

endmodule

// File: tb/tb_iob_eth_dma_burst.sv
// Directed bench for iob_eth_dma_burst: reactive AXI slave, TX/RX buffer models
// and hand-computed expectations for bursts, 4 KB splits, stalls, errors and reset.
module tb_iob_eth_dma_burst;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic [31:0] dma_addr = 32'd0;
  logic [10:0] dma_len = 11'd0;
  logic        dma_dir = 1'b0;
  logic        dma_run = 1'b0;
  logic        dma_ready, dma_error;
  logic [31:0] buf_wdata;
  logic [10:0] buf_waddr, buf_raddr;
  logic        buf_we;
  logic [31:0] buf_rdata = 32'd0;
  logic [0:0]  awid, arid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache, awqos, arqos;
  logic        awvalid, arvalid, wvalid, wlast, bready, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'd0;
  logic [0:0]  bid = 1'b0, rid = 1'b0;

  iob_eth_dma_burst dut (
    .clk(clk), .rst_n(rst_n),
    .dma_addr(dma_addr), .dma_len(dma_len), .dma_dir(dma_dir), .dma_run(dma_run),
    .dma_ready(dma_ready), .dma_error(dma_error),
    .buf_wdata(buf_wdata), .buf_waddr(buf_waddr), .buf_we(buf_we),
    .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 | {16'h0000, a[15:0]};
  endfunction

  function automatic logic [31:0] tx_word(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  // Buffer models: TX RAM with one-cycle read latency, RX RAM written on buf_we.
  logic [31:0] txbuf [0:2047];
  logic [31:0] rxbuf [0:2047];
  int rx_wr_cnt = 0;
  always @(posedge clk) begin
    buf_rdata <= txbuf[buf_raddr];
    if (buf_we) begin
      rxbuf[buf_waddr] <= buf_wdata;
      rx_wr_cnt <= rx_wr_cnt + 1;
    end
  end

  // Slave configuration (written by the stimulus) and transaction logs (written by the slave).
  int aw_delay = 0;
  bit w_toggle = 1'b0;
  bit r_gap = 1'b0;
  int err_burst = -1;
  logic [31:0] aw_addr_q[$], ar_addr_q[$], w_data_q[$];
  int aw_len_q[$], ar_len_q[$];
  bit w_last_q[$];
  int b_count = 0;
  int r_hs_total = 0;

  logic [31:0] rq_addr[$];
  int rq_len[$];
  int aw_cnt = 0, b_pend = 0, r_beat = 0, r_cyc = 0;
  bit b_took = 1'b0, r_took = 1'b0;

  // Reactive AXI slave; inputs change at negedge, handshakes are those seen at the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      aw_cnt = 0; b_pend = 0; r_beat = 0; b_took = 1'b0; r_took = 1'b0;
      rq_addr.delete(); rq_len.delete();
    end else begin
      if (b_took || !bvalid) begin
        b_took = 1'b0;
        bvalid = (b_pend > 0);
        bresp = (b_count == err_burst) ? 2'b10 : 2'b00;
      end
      if (bvalid && bready) begin
        b_took = 1'b1; b_pend--; b_count++;
      end
      if (r_took || !rvalid) begin
        r_took = 1'b0;
        if (rq_addr.size() > 0) begin
          rvalid = !(r_gap && (r_cyc % 3 == 0));
          r_cyc++;
          rdata = mem_word(rq_addr[0] + 32'(4 * r_beat));
          rlast = (r_beat == rq_len[0]);
        end else begin
          rvalid = 1'b0; rlast = 1'b0;
        end
      end
      if (rvalid && rready) begin
        r_took = 1'b1; r_hs_total++;
        if (r_beat == rq_len[0]) begin
          void'(rq_addr.pop_front()); void'(rq_len.pop_front()); r_beat = 0;
        end else begin
          r_beat++;
        end
      end
      awready = awvalid && (aw_cnt >= aw_delay);
      if (awvalid && awready) begin
        aw_addr_q.push_back(awaddr); aw_len_q.push_back(int'(awlen)); aw_cnt = 0;
      end else if (awvalid) aw_cnt++;
      else aw_cnt = 0;
      wready = w_toggle ? !wready : 1'b1;
      if (wvalid && wready) begin
        w_data_q.push_back(wdata); w_last_q.push_back(wlast);
        if (wlast) b_pend++;
      end
      arready = arvalid;
      if (arvalid && arready) begin
        ar_addr_q.push_back(araddr); ar_len_q.push_back(int'(arlen));
        rq_addr.push_back(araddr); rq_len.push_back(int'(arlen));
      end
    end
  end

  task automatic start(input logic [31:0] a, input logic [10:0] l, input logic d);
    @(negedge clk);
    dma_addr = a; dma_len = l; dma_dir = d; dma_run = 1'b1;
    @(negedge clk);
    dma_run = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!dma_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(dma_ready), 64'd1);
  endtask

  int awb, arb, wb, rxb, busy;

  initial begin
    for (int i = 0; i < 2048; i++) txbuf[i] = tx_word(i);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 64'(dma_ready), 64'd1);
    check_eq("rst_error", 64'(dma_error), 64'd0);
    check_eq("rst_valids", 64'({awvalid, arvalid, wvalid}), 64'd0);
    check_eq("rst_readies", 64'({bready, rready}), 64'd0);
    check_eq("rst_buf", 64'({buf_we, buf_waddr, buf_raddr}), 64'd0);
    check_eq("rst_ax", 64'({awaddr, awlen}), 64'd0);

    // Read split 0x1000, 40 beats
    arb = ar_addr_q.size(); rxb = rx_wr_cnt;
    start(32'h0000_1000, 11'd40, 1'b0);
    check_eq("t1_busy", 64'(dma_ready), 64'd0);
    @(negedge clk);
    check_eq("t1_arvalid", 64'(arvalid), 64'd1);
    check_eq("t1_arfields", 64'({arsize, arburst, arcache, arprot, arlock, arqos, arid}),
             64'({3'd2, 2'b01, 4'b0011, 3'b010, 1'b0, 4'd0, 1'b0}));
    wait_done("t1_done");
    check_eq("t1_ar_n", 64'(ar_addr_q.size() - arb), 64'd3);
    check_eq("t1_ar0", 64'({ar_addr_q[arb], 8'(ar_len_q[arb])}), 64'h1000_0F);
    check_eq("t1_ar1", 64'({ar_addr_q[arb+1], 8'(ar_len_q[arb+1])}), 64'h1040_0F);
    check_eq("t1_ar2", 64'({ar_addr_q[arb+2], 8'(ar_len_q[arb+2])}), 64'h1080_07);
    check_eq("t1_rx_n", 64'(rx_wr_cnt - rxb), 64'd40);
    for (int i = 0; i < 40; i++)
      check_eq($sformatf("t1_rx[%0d]", i), 64'(rxbuf[i]), 64'(32'hA500_1000 + 32'(4 * i)));
    check_eq("t1_error", 64'(dma_error), 64'd0);

    // Write across a 4 KB boundary
    awb = aw_addr_q.size(); wb = w_data_q.size();
    start(32'h0000_0FF8, 11'd4, 1'b1);
    wait_done("t2_done");
    check_eq("t2_aw_n", 64'(aw_addr_q.size() - awb), 64'd2);
    check_eq("t2_aw0", 64'({aw_addr_q[awb], 8'(aw_len_q[awb])}), 64'h0FF8_01);
    check_eq("t2_aw1", 64'({aw_addr_q[awb+1], 8'(aw_len_q[awb+1])}), 64'h1000_01);
    check_eq("t2_w_n", 64'(w_data_q.size() - wb), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t2_wdata[%0d]", i), 64'(w_data_q[wb+i]), 64'(tx_word(i)));
      check_eq($sformatf("t2_wlast[%0d]", i), 64'(w_last_q[wb+i]), 64'(i % 2));
    end
    check_eq("t2_wstrb", 64'(wstrb), 64'hF);
    check_eq("t2_awsize", 64'({awsize, awburst, awcache, awprot}), 64'({3'd2, 2'b01, 4'b0011, 3'b010}));

    // Backpressured write then read with rvalid gaps
    aw_delay = 5; w_toggle = 1'b1;
    awb = aw_addr_q.size(); wb = w_data_q.size();
    start(32'h0000_2000, 11'd20, 1'b1);
    wait_done("t3w_done");
    check_eq("t3_aw_n", 64'(aw_addr_q.size() - awb), 64'd2);
    check_eq("t3_aw1", 64'({aw_addr_q[awb+1], 8'(aw_len_q[awb+1])}), 64'h2040_03);
    check_eq("t3_w_n", 64'(w_data_q.size() - wb), 64'd20);
    for (int i = 0; i < 20; i++) begin
      check_eq($sformatf("t3_wdata[%0d]", i), 64'(w_data_q[wb+i]), 64'(tx_word(i)));
      check_eq($sformatf("t3_wlast[%0d]", i), 64'(w_last_q[wb+i]), 64'((i == 15) || (i == 19)));
    end
    aw_delay = 0; w_toggle = 1'b0; r_gap = 1'b1;
    rxb = rx_wr_cnt;
    start(32'h0000_3000, 11'd20, 1'b0);
    wait_done("t3r_done");
    check_eq("t3_rx_n", 64'(rx_wr_cnt - rxb), 64'd20);
    for (int i = 0; i < 20; i++)
      check_eq($sformatf("t3_rx[%0d]", i), 64'(rxbuf[i]), 64'(32'hA500_3000 + 32'(4 * i)));
    r_gap = 1'b0;

    // SLVERR on the second of three write bursts
    err_burst = b_count + 1;
    awb = aw_addr_q.size();
    start(32'h0000_4000, 11'd40, 1'b1);
    wait_done("t4_done");
    check_eq("t4_aw_n", 64'(aw_addr_q.size() - awb), 64'd3);
    check_eq("t4_aw2", 64'({aw_addr_q[awb+2], 8'(aw_len_q[awb+2])}), 64'h4080_07);
    check_eq("t4_error", 64'(dma_error), 64'd1);
    err_burst = -1;

    // Zero-length start: clears the error, no traffic, stays ready
    awb = aw_addr_q.size(); arb = ar_addr_q.size(); busy = 0;
    start(32'h0000_8000, 11'd0, 1'b0);
    repeat (6) begin
      if (!dma_ready) busy++;
      @(negedge clk);
    end
    check_eq("t5_zero_busy", 64'(busy), 64'd0);
    check_eq("t5_zero_error", 64'(dma_error), 64'd0);
    check_eq("t5_zero_traffic", 64'((aw_addr_q.size() - awb) + (ar_addr_q.size() - arb)), 64'd0);

    // dma_run while busy is ignored
    arb = ar_addr_q.size(); awb = aw_addr_q.size(); rxb = rx_wr_cnt;
    start(32'h0000_5000, 11'd8, 1'b0);
    @(negedge clk);
    dma_addr = 32'h0000_9000; dma_len = 11'd3; dma_dir = 1'b1; dma_run = 1'b1;
    @(negedge clk);
    dma_run = 1'b0;
    wait_done("t5_done");
    repeat (4) @(negedge clk);
    check_eq("t5_ar_n", 64'(ar_addr_q.size() - arb), 64'd1);
    check_eq("t5_aw_n", 64'(aw_addr_q.size() - awb), 64'd0);
    check_eq("t5_rx_n", 64'(rx_wr_cnt - rxb), 64'd8);
    check_eq("t5_rx7", 64'(rxbuf[7]), 64'h A500_501C);

    // Reset during beat 5 of a read burst
    rxb = r_hs_total;
    start(32'h0000_6000, 11'd16, 1'b0);
    begin
      int n = 0;
      while ((r_hs_total - rxb) < 5 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("t6_reached_beat5", 64'(r_hs_total - rxb), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_rready", 64'(rready), 64'd0);
    check_eq("t6_rst_arvalid", 64'(arvalid), 64'd0);
    check_eq("t6_rst_ready", 64'(dma_ready), 64'd1);
    check_eq("t6_rst_we", 64'(buf_we), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    arb = ar_addr_q.size(); rxb = rx_wr_cnt;
    start(32'h0000_7000, 11'd8, 1'b0);
    wait_done("t6_done");
    check_eq("t6_ar", 64'({32'(ar_addr_q.size() - arb), 8'(ar_len_q[arb])}), 64'h1_07);
    check_eq("t6_rx_n", 64'(rx_wr_cnt - rxb), 64'd8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("t6_rx[%0d]", i), 64'(rxbuf[i]), 64'(32'hA500_7000 + 32'(4 * i)));
    check_eq("t6_error", 64'(dma_error), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
